// File: rtl/dmem_if.sv
// MEM-stage data-memory bus: byte address, store data,
// byte write strobes and same-cycle read data.
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] wrdata;
  logic [3:0]  wrstb;
  logic [31:0] rddata;

  modport master (
    output addr,
    output wrdata,
    output wrstb,
    input  rddata
  );

  modport slave (
    input  addr,
    input  wrdata,
    input  wrstb,
    output rddata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: combinational word loads, byte-strobed
// stores, and a 4 KiB MMIO window with CYCLE, SCRATCH and STATUS.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  // reset value of CYCLE; keep 0 outside of wrap-around checks
  parameter logic [31:0] CYCLE_RST   = 32'h0
) (
  input  logic    clk,
  input  logic    rst,
  dmem_if.slave   dmem,
  output logic    fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   cycle;
  logic [31:0]   scratch;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          ram_hit;
  logic          mmio_hit;
  logic [9:0]    off;
  logic          aligned;
  logic          wr;
  logic          wr_ok;
  logic          sel_cycle;
  logic          sel_scr;
  logic          sel_stat;
  logic          ram_we;
  logic          set_fault;
  logic          clr_fault;
  logic [AW-1:0] ram_idx;

  assign ram_hit   = (dmem.addr[31:AW+2] == '0);
  assign mmio_hit  = (dmem.addr[31:12] == MMIO_BASE[31:12]);
  assign off       = dmem.addr[11:2];
  assign aligned   = (dmem.addr[1:0] == 2'b00);
  assign ram_idx   = dmem.addr[AW+1:2];

  assign sel_cycle = mmio_hit && (off == 10'd0);
  assign sel_scr   = mmio_hit && (off == 10'd1);
  assign sel_stat  = mmio_hit && (off == 10'd2);

  assign wr        = |dmem.wrstb;
  assign wr_ok     = wr && aligned;
  assign ram_we    = wr_ok && ram_hit;

  // misaligned stores fault and are suppressed everywhere
  assign set_fault = wr && (!aligned
                         || !(ram_hit || mmio_hit)
                         || (mmio_hit && (off > 10'd2)));
  assign clr_fault = wr_ok && sel_stat
                  && dmem.wrstb[0] && dmem.wrdata[0];

  always_comb begin
    dmem.rddata = 32'h0;
    unique case (1'b1)
      ram_hit:   dmem.rddata = mem[ram_idx];
      sel_cycle: dmem.rddata = cycle;
      sel_scr:   dmem.rddata = scratch;
      sel_stat:  dmem.rddata = {31'b0, fault};
      default:   dmem.rddata = 32'h0;
    endcase
  end

  // RAM is never reset and keeps committing stores during reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && dmem.wrstb[i])
        mem[ram_idx][8*i +: 8] <= dmem.wrdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle   <= CYCLE_RST;
      scratch <= 32'h0;
      fault   <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      for (int i = 0; i < 4; i++) begin
        if (wr_ok && sel_scr && dmem.wrstb[i])
          scratch[8*i +: 8] <= dmem.wrdata[8*i +: 8];
      end
      if (set_fault)
        fault <= 1'b1;
      else if (clr_fault)
        fault <= 1'b0;
    end
  end

endmodule
